// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (serial-in or rotate), parallel load,
// with synchronous preset/clear, a saturating shift counter and a registered serial output.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter bit               ROTATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_prn,
    input  logic                         i_clrn,
    input  logic                         i_en,
    input  logic [1:0]                   i_mode,
    input  logic [WIDTH-1:0]             i_D,
    input  logic                         i_sin,
    output logic [WIDTH-1:0]             o_Q,
    output logic                         o_sout,
    output logic [$clog2(WIDTH+1)-1:0]   o_cnt,
    output logic                         o_full
);

    localparam int               CNT_W   = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // The counter sticks at WIDTH so "full" stays asserted until the next load/preset/clear.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] q, input logic in_bit);
        return {in_bit, q[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] q, input logic in_bit);
        return {q[WIDTH-2:0], in_bit};
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shr_in;
    logic             shl_in;

    assign shr_in = ROTATE ? o_Q[0]       : i_sin;
    assign shl_in = ROTATE ? o_Q[WIDTH-1] : i_sin;

    always_comb begin
        q_nxt    = o_Q;
        sout_nxt = o_sout;
        cnt_nxt  = o_cnt;
        if (!i_prn) begin
            q_nxt   = '1;
            cnt_nxt = '0;
        end else if (!i_clrn) begin
            q_nxt   = '0;
            cnt_nxt = '0;
        end else if (i_en) begin
            case (i_mode)
                MODE_SHR: begin
                    q_nxt    = shift_right(o_Q, shr_in);
                    sout_nxt = o_Q[0];
                    cnt_nxt  = sat_inc(o_cnt);
                end
                MODE_SHL: begin
                    q_nxt    = shift_left(o_Q, shl_in);
                    sout_nxt = o_Q[WIDTH-1];
                    cnt_nxt  = sat_inc(o_cnt);
                end
                MODE_LOAD: begin
                    q_nxt   = i_D;
                    cnt_nxt = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_Q    <= RESET_VAL;
            o_sout <= 1'b0;
            o_cnt  <= '0;
        end else begin
            o_Q    <= q_nxt;
            o_sout <= sout_nxt;
            o_cnt  <= cnt_nxt;
        end
    end

    assign o_full = (o_cnt == CNT_MAX);

endmodule
